// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: prescaled 100 Hz timebase, BCD mm:ss.cc counter,
// run/pause/lap FSM with a frozen lap display and a wrap pulse at 59:59.99.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_stop_i,
  input  logic        lap_i,
  input  logic        clear_i,
  output logic        tick_o,
  output logic [1:0]  state_o,
  output logic [23:0] time_o,
  output logic [23:0] disp_o,
  output logic        wrap_o
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  state_t        r_state = S_IDLE;
  logic [PW-1:0] r_presc = '0;
  logic          r_tick  = 1'b0;
  logic          r_wrap  = 1'b0;
  logic [23:0]   r_time  = '0;
  logic [23:0]   r_snap  = '0;
  logic [23:0]   r_disp  = '0;

  state_t        w_state_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic          w_tick_nxt;
  logic          w_wrap_nxt;
  logic [23:0]   w_time_nxt;
  logic [23:0]   w_snap_nxt;
  logic [23:0]   w_disp_nxt;
  logic [24:0]   w_inc;
  logic          w_counting;

  // Ripple-carry BCD increment over digits cc1,cc10,ss1,ss10,mm1,mm10;
  // bit 24 of the result is the carry out of 59:59.99.
  function automatic logic [24:0] bcd_inc(input logic [23:0] t);
    logic [23:0] v;
    logic        c;
    logic [3:0]  d;
    logic [3:0]  lim;
    v = t;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d   = v[i*4 +: 4];
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (c) begin
        v[i*4 +: 4] = (d == lim) ? 4'd0 : d + 4'd1;
        c = (d == lim);
      end
    end
    return {c, v};
  endfunction

  assign w_inc      = bcd_inc(r_time);
  assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_tick_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_time_nxt  = r_time;
    w_snap_nxt  = r_snap;

    if (w_counting) begin
      if (r_presc == PRESC_LAST) begin
        w_presc_nxt = '0;
        w_tick_nxt  = 1'b1;
        w_time_nxt  = w_inc[23:0];
        w_wrap_nxt  = w_inc[24];
      end else begin
        w_presc_nxt = r_presc + 1'b1;
      end
    end

    // start_stop wins over lap/clear; lap and clear only act in their states
    case (r_state)
      S_IDLE:  if (start_stop_i) w_state_nxt = S_RUN;
      S_RUN: begin
        if (start_stop_i)  w_state_nxt = S_PAUSE;
        else if (lap_i)    w_state_nxt = S_LAP;
      end
      S_LAP: begin
        if (start_stop_i)  w_state_nxt = S_PAUSE;
        else if (lap_i)    w_state_nxt = S_RUN;
      end
      S_PAUSE: begin
        if (start_stop_i)  w_state_nxt = S_RUN;
        else if (clear_i)  w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Snapshot includes an increment landing on the same edge
    if (r_state == S_RUN && w_state_nxt == S_LAP)
      w_snap_nxt = w_time_nxt;

    if (r_state == S_PAUSE && w_state_nxt == S_IDLE) begin
      w_presc_nxt = '0;
      w_time_nxt  = '0;
      w_snap_nxt  = '0;
    end

    w_disp_nxt = (w_state_nxt == S_LAP) ? w_snap_nxt : w_time_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_time  <= '0;
      r_snap  <= '0;
      r_disp  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_tick  <= w_tick_nxt;
      r_wrap  <= w_wrap_nxt;
      r_time  <= w_time_nxt;
      r_snap  <= w_snap_nxt;
      r_disp  <= w_disp_nxt;
    end
  end

  assign tick_o  = r_tick;
  assign wrap_o  = r_wrap;
  assign state_o = r_state;
  assign time_o  = r_time;
  assign disp_o  = r_disp;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, clk_i cycles per timebase tick (100 MHz -> 100 Hz); legal range 2..2^21.
REQ-002 SHALL have port clk_i  input  1  system clock (100 MHz); the block has one clock.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_stop_i  input  1  single-cycle command pulse, debounced upstream.
REQ-005 SHALL have port lap_i  input  1  single-cycle lap-toggle pulse.
REQ-006 SHALL have port clear_i  input  1  single-cycle clear pulse.
REQ-007 SHALL have port tick_o  output  1  one-cycle timebase pulse, asserted only while counting.
REQ-008 SHALL have port state_o  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP.
REQ-009 SHALL have port time_o  output  24  live BCD time {mm[7:0], ss[7:0], cc[7:0]}.
REQ-010 SHALL have port disp_o  output  24  display value: lap snapshot in LAP, else equal to time_o.
REQ-011 SHALL have port wrap_o  output  1  one-cycle pulse when time_o wraps 59:59.99 -> 00:00.00.

Function
REQ-012 SHALL contain an internal prescaler counting 0..TICK_DIV-1, advancing only in RUN or LAP, holding its value in PAUSE.
REQ-013 SHALL assert tick_o (registered) for exactly one cycle on the edge where the prescaler wraps from TICK_DIV-1 to 0, giving a tick period of exactly TICK_DIV cycles.
REQ-014 SHALL increment time_o on the same edge that asserts tick_o: cc 00..99, carry to ss 00..59, carry to mm 00..59, every digit valid BCD.
REQ-015 SHALL, on tick at 59:59.99, set time_o to 00:00.00, assert wrap_o for that one cycle, and remain in the current state.
REQ-016 SHALL apply transitions: IDLE+start_stop -> RUN; RUN+start_stop -> PAUSE; RUN+lap -> LAP; LAP+lap -> RUN; LAP+start_stop -> PAUSE; PAUSE+start_stop -> RUN; PAUSE+clear -> IDLE.
REQ-017 SHALL, on RUN -> LAP, load the lap snapshot with the time_o value present in that cycle (including any increment made on the same edge).
REQ-018 SHALL continue incrementing time_o and ticking while in LAP; only disp_o is frozen.
REQ-019 SHALL, on PAUSE -> IDLE via clear, zero time_o, the prescaler and the lap snapshot on that edge.
REQ-020 SHALL ignore clear_i in RUN and LAP, and ignore lap_i in IDLE and PAUSE.
REQ-021 SHALL give start_stop_i priority over lap_i and clear_i when asserted in the same cycle.
REQ-022 SHALL preserve the prescaler residual across PAUSE, so that RUN-time accumulated across pauses is exact to one clk_i cycle.
REQ-023 SHALL make a state change visible on state_o one cycle after the command pulse; the first tick after IDLE -> RUN SHALL occur TICK_DIV cycles after the edge that entered RUN.
REQ-024 SHALL keep every output registered, with no combinational path from the inputs to the outputs.

Reset
REQ-025 SHALL, while rst_i=1 at a clk_i edge, set state to IDLE, the prescaler to 0, time_o, disp_o and the snapshot to 24'h000000, and tick_o and wrap_o to 0.
REQ-026 SHALL let rst_i override all commands in the same cycle, including reset asserted mid-RUN or mid-LAP.
REQ-027 SHALL have all registers use the same power-up value as the reset value.

Verification (TICK_DIV=4)
REQ-028 SHALL cover reset: rst_i 1 for 2 cycles -> state_o=00, time_o=disp_o=0, tick_o=wrap_o=0.
REQ-029 SHALL cover start: start_stop at edge k -> state_o=01 after edge k; tick_o at edges k+4, k+8, ...; after 100 ticks, time_o=24'h000100.
REQ-030 SHALL cover pause residual: pause 2 cycles after a tick, hold 50 cycles, resume -> next tick exactly 2 RUN cycles after resume; tick_o stays 0 and time_o holds during PAUSE.
REQ-031 SHALL cover lap: lap at time 00:00.37 -> disp_o=24'h000037 held while time_o advances; second lap -> disp_o tracks time_o again.
REQ-032 SHALL cover wrap: drive the count to 59:59.99 and tick -> time_o=0, wrap_o=1 for one cycle, state_o stays 01.
REQ-033 SHALL cover simultaneous commands and reset: start_stop+lap in RUN -> PAUSE with no snapshot taken; clear in RUN -> ignored; clear in PAUSE -> IDLE with all values 0; rst_i mid-LAP -> all reset values.
